// File: rtl/decode_sequencer_pkg.sv
// rtl/decode_sequencer_pkg.sv - shared encodings for the ID-stage decode sequencer
package decode_sequencer_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int OPC_W_DEF   = 5;
    localparam int RADDR_W_DEF = 3;
    localparam int CNT_W_DEF   = 16;

    // Opcodes whose top two bits match this prefix are followed by an immediate word
    localparam logic [1:0] IMM_PREFIX = 2'b11;

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_IMM  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/decode_sequencer.sv
// rtl/decode_sequencer.sv - assembles one/two-word instructions into registered bundles for EX
module decode_sequencer
    import decode_sequencer_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int OPC_W   = OPC_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               instr_valid,
    input  logic [WIDTH-1:0]   instruction,
    output logic               instr_ready,
    input  logic               ex_ready,
    output logic               dec_valid,
    output logic [OPC_W-1:0]   dec_opcode,
    output logic [RADDR_W-1:0] dec_rs1,
    output logic [RADDR_W-1:0] dec_rs2,
    output logic [RADDR_W-1:0] dec_rd,
    output logic               dec_has_imm,
    output logic [WIDTH-1:0]   dec_imm,
    output logic               rf_read_enable,
    output logic [CNT_W-1:0]   dec_count
);

    localparam int RS1_MSB = WIDTH - OPC_W - 1;
    localparam int RS2_MSB = RS1_MSB - RADDR_W;
    localparam int RD_MSB  = RS2_MSB - RADDR_W;

    state_t             state;
    logic               accept;
    logic               retire;
    logic               two_word;
    logic [OPC_W-1:0]   w_opc;
    logic [CNT_W-1:0]   cnt_one;

    // Single-entry holding stage: a new word is only taken in S_HOLD when the bundle leaves
    assign instr_ready    = rst & ~flush & ((state != S_HOLD) | ex_ready);
    assign accept         = instr_valid & instr_ready;
    assign retire         = dec_valid & ex_ready;
    assign w_opc          = instruction[WIDTH-1 -: OPC_W];
    assign two_word       = (w_opc[OPC_W-1 -: 2] == IMM_PREFIX);
    assign rf_read_enable = dec_valid;
    assign cnt_one        = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_OP;
            dec_valid   <= 1'b0;
            dec_opcode  <= '0;
            dec_rs1     <= '0;
            dec_rs2     <= '0;
            dec_rd      <= '0;
            dec_has_imm <= 1'b0;
            dec_imm     <= '0;
            dec_count   <= '0;
        end else begin
            // A bundle leaving in the flush cycle was already handed over, so it still counts
            if (retire) begin
                dec_count <= dec_count + cnt_one;
            end

            if (flush) begin
                dec_valid   <= 1'b0;
                dec_has_imm <= 1'b0;
                dec_imm     <= '0;
                state       <= S_OP;
            end else begin
                case (state)
                    S_OP, S_HOLD: begin
                        if (accept) begin
                            dec_opcode <= w_opc;
                            dec_rs1    <= instruction[RS1_MSB -: RADDR_W];
                            dec_rs2    <= instruction[RS2_MSB -: RADDR_W];
                            dec_rd     <= instruction[RD_MSB -: RADDR_W];
                            dec_imm    <= '0;
                            if (two_word) begin
                                dec_has_imm <= 1'b1;
                                dec_valid   <= 1'b0;
                                state       <= S_IMM;
                            end else begin
                                dec_has_imm <= 1'b0;
                                dec_valid   <= 1'b1;
                                state       <= S_HOLD;
                            end
                        end else if (state == S_HOLD && ex_ready) begin
                            dec_valid <= 1'b0;
                            state     <= S_OP;
                        end
                    end
                    S_IMM: begin
                        if (accept) begin
                            dec_imm   <= instruction;
                            dec_valid <= 1'b1;
                            state     <= S_HOLD;
                        end
                    end
                    default: begin
                        dec_valid <= 1'b0;
                        state     <= S_OP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode_sequencer.sv
// tb/tb_decode_sequencer.sv - directed bench with an occupancy-level reference model
module tb_decode_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        instr_valid;
    logic [15:0] instruction;
    logic        instr_ready;
    logic        ex_ready;
    logic        dec_valid;
    logic [4:0]  dec_opcode;
    logic [2:0]  dec_rs1;
    logic [2:0]  dec_rs2;
    logic [2:0]  dec_rd;
    logic        dec_has_imm;
    logic [15:0] dec_imm;
    logic        rf_read_enable;
    logic [15:0] dec_count;

    always #5 clk = ~clk;

    decode_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .instr_ready    (instr_ready),
        .ex_ready       (ex_ready),
        .dec_valid      (dec_valid),
        .dec_opcode     (dec_opcode),
        .dec_rs1        (dec_rs1),
        .dec_rs2        (dec_rs2),
        .dec_rd         (dec_rd),
        .dec_has_imm    (dec_has_imm),
        .dec_imm        (dec_imm),
        .rf_read_enable (rf_read_enable),
        .dec_count      (dec_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: "is a bundle presented", "is half an instruction buffered", and its contents
    bit          m_valid   = 0;
    bit          m_partial = 0;
    bit          m_has_imm = 0;
    logic [4:0]  m_opc     = '0;
    logic [2:0]  m_rs1     = '0;
    logic [2:0]  m_rs2     = '0;
    logic [2:0]  m_rd      = '0;
    logic [15:0] m_imm     = '0;
    int          m_count   = 0;
    bit          m_rdy;
    bit          started   = 0;

    always @(posedge clk) begin
        started = 1;
        m_rdy = rst && !flush && (!m_valid || ex_ready);
        if (!rst) begin
            m_valid = 0; m_partial = 0; m_has_imm = 0;
            m_opc = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_imm = '0;
            m_count = 0;
        end else begin
            if (m_valid && ex_ready) begin
                m_count = (m_count + 1) % 65536;
                m_valid = 0;
            end
            if (flush) begin
                m_valid = 0; m_partial = 0; m_has_imm = 0; m_imm = '0;
            end else if (instr_valid && m_rdy) begin
                if (m_partial) begin
                    m_imm     = instruction;
                    m_partial = 0;
                    m_valid   = 1;
                end else begin
                    m_opc = instruction[15:11];
                    m_rs1 = instruction[10:8];
                    m_rs2 = instruction[7:5];
                    m_rd  = instruction[4:2];
                    m_imm = '0;
                    if (instruction[15:14] == 2'b11) begin
                        m_partial = 1;
                        m_has_imm = 1;
                    end else begin
                        m_has_imm = 0;
                        m_valid   = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("instr_ready", instr_ready, rst && !flush && (!m_valid || ex_ready));
            chk("dec_valid", dec_valid, m_valid);
            chk("rf_read_enable", rf_read_enable, m_valid);
            chk("dec_count", dec_count, m_count);
            if (m_valid) begin
                chk("dec_opcode", dec_opcode, m_opc);
                chk("dec_rs1", dec_rs1, m_rs1);
                chk("dec_rs2", dec_rs2, m_rs2);
                chk("dec_rd", dec_rd, m_rd);
                chk("dec_has_imm", dec_has_imm, m_has_imm);
                chk("dec_imm", dec_imm, m_imm);
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] w, input logic er,
                        input logic fl, input logic r);
        instr_valid = v;
        instruction = w;
        ex_ready    = er;
        flush       = fl;
        rst         = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, dec_valid, 0);
        chk({tag, "_opcode"}, dec_opcode, 0);
        chk({tag, "_regs"}, {dec_rs1, dec_rs2, dec_rd}, 0);
        chk({tag, "_has_imm"}, dec_has_imm, 0);
        chk({tag, "_imm"}, dec_imm, 0);
        chk({tag, "_rf_re"}, rf_read_enable, 0);
        chk({tag, "_count"}, dec_count, 0);
    endtask

    initial begin
        int guard;
        rst = 1'b0; flush = 1'b0; instr_valid = 1'b0; instruction = '0; ex_ready = 1'b0;

        // Reset for two cycles, then release
        step(0, 16'h0000, 1, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        chk_all_zero("rst");
        chk("rst_instr_ready", instr_ready, 0);
        rst = 1'b1;
        #1;
        chk("release_instr_ready", instr_ready, 1);
        step(0, 16'h0000, 1, 0, 1);

        // Back-to-back single-word instructions
        step(1, 16'h0A94, 1, 0, 1);
        chk("t2_valid", dec_valid, 1);
        chk("t2_opcode", dec_opcode, 5'h01);
        chk("t2_rs1", dec_rs1, 2);
        chk("t2_rs2", dec_rs2, 4);
        chk("t2_rd", dec_rd, 5);
        step(1, 16'h1234, 1, 0, 1);
        chk("t2b_valid", dec_valid, 1);
        chk("t2b_opcode", dec_opcode, 5'h02);
        step(0, 16'h0000, 1, 0, 1);
        chk("t2_idle_valid", dec_valid, 0);
        chk("t2_count", dec_count, 2);

        // Two-word instruction
        step(1, 16'hC8A4, 1, 0, 1);
        chk("t3_no_valid_yet", dec_valid, 0);
        step(1, 16'hBEEF, 1, 0, 1);
        chk("t3_valid", dec_valid, 1);
        chk("t3_opcode", dec_opcode, 5'h19);
        chk("t3_has_imm", dec_has_imm, 1);
        chk("t3_imm", dec_imm, 16'hBEEF);

        // EX back-pressure with the next word waiting
        for (int i = 0; i < 5; i++) begin
            step(1, 16'h1234, 0, 0, 1);
            chk("t4_instr_ready", instr_ready, 0);
            chk("t4_hold_imm", dec_imm, 16'hBEEF);
            chk("t4_hold_valid", dec_valid, 1);
        end
        step(1, 16'h1234, 1, 0, 1);
        chk("t4_next_opcode", dec_opcode, 5'h02);
        chk("t4_next_rs2", dec_rs2, 1);
        chk("t4_next_has_imm", dec_has_imm, 0);
        chk("t4_count", dec_count, 3);
        step(0, 16'h0000, 1, 0, 1);
        chk("t4_count_after", dec_count, 4);

        // Flush drops a half-assembled instruction
        step(1, 16'hC8A4, 1, 0, 1);
        step(0, 16'h0000, 1, 1, 1);
        chk("t5_flush_valid", dec_valid, 0);
        chk("t5_flush_has_imm", dec_has_imm, 0);
        step(1, 16'h0A94, 1, 0, 1);
        chk("t5_valid", dec_valid, 1);
        chk("t5_has_imm", dec_has_imm, 0);
        chk("t5_opcode", dec_opcode, 5'h01);
        step(0, 16'h0000, 1, 0, 1);
        chk("t5_count", dec_count, 5);

        // Counter wrap
        guard = 0;
        while (m_count != 16'hFFFF && guard < 70000) begin
            step(1, 16'h0A94, 1, 0, 1);
            guard++;
        end
        if (guard >= 70000) chk("t6_wrap_budget", guard, 0);
        chk("t6_count_max", dec_count, 16'hFFFF);
        step(0, 16'h0000, 1, 0, 1);
        chk("t6_count_wrap", dec_count, 0);

        // Reset while waiting for an immediate
        step(1, 16'hC8A4, 1, 0, 1);
        chk("t6_imm_pending_has_imm", dec_has_imm, 1);
        step(0, 16'h0000, 1, 0, 0);
        chk_all_zero("t6_rst");
        step(0, 16'h0000, 1, 0, 1);
        chk("t6_ready_after_rst", instr_ready, 1);
        step(1, 16'h1234, 1, 0, 1);
        chk("t6_single_after_rst", dec_has_imm, 0);
        chk("t6_valid_after_rst", dec_valid, 1);
        step(0, 16'h0000, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
